// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and parameter legality checks for fifo_lvl
package fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int depth, input int af_thr, input int ae_thr);
    return is_pow2(depth)
        && (af_thr >= 1) && (af_thr <= depth)
        && (ae_thr >= 0) && (ae_thr <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage array, synchronous write and asynchronous read
module fifo_mem #(
  parameter int DataWidth = 8,
  parameter int Depth     = 16,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [DataWidth-1:0] i_wr_data,
  input  logic [AddrWidth-1:0] i_rd_addr,
  output logic [DataWidth-1:0] o_rd_data
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/fifo_lvl.sv
// rtl/fifo_lvl.sv - synchronous FIFO with fill level, thresholds, sticky errors, flush
// and selectable registered-read or first-word-fall-through output.
module fifo_lvl
  import fifo_pkg::*;
#(
  parameter int DataWidth      = 8,
  parameter int Depth          = 16,
  parameter bit Fwft           = 1'b0,
  parameter int AlmostFullThr  = Depth - 2,
  parameter int AlmostEmptyThr = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DataWidth-1:0]      i_wr_data,
  input  logic                      i_wr_en,
  input  logic                      i_rd_en,
  input  logic                      i_clr,
  output logic [DataWidth-1:0]      o_rd_data,
  output logic                      o_rd_valid,
  output logic [cnt_w(Depth)-1:0]   o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_almost_full,
  output logic                      o_almost_empty,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int AW = $clog2(Depth);
  localparam int CW = cnt_w(Depth);
  localparam logic [CW-1:0] DepthC = CW'(Depth);
  localparam logic [CW-1:0] AfThrC = CW'(AlmostFullThr);
  localparam logic [CW-1:0] AeThrC = CW'(AlmostEmptyThr);

  if (!params_ok(Depth, AlmostFullThr, AlmostEmptyThr)) begin : g_bad_params
    $error("fifo_lvl: Depth must be a power of two >= 2 and thresholds in range");
  end

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 afull_q, afull_d;
  logic                 aempty_q, aempty_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [DataWidth-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;

  logic                 rd_ok, wr_ok, mem_we;
  logic [DataWidth-1:0] mem_rd_data;

  // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
  assign rd_ok  = i_rd_en & ~empty_q;
  assign wr_ok  = i_wr_en & (~full_q | rd_ok);
  assign mem_we = wr_ok & ~i_clr;

  fifo_mem #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .AddrWidth (AW)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (mem_we),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (mem_rd_data)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_data_d  = mem_rd_data;
        rd_valid_d = 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (i_wr_en & ~wr_ok)   ovf_d = 1'b1;
      if (i_rd_en & empty_q)  unf_d = 1'b1;
    end

    // Flags follow next-count so they move on the same edge as o_count.
    full_d   = (count_d == DepthC);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfThrC);
    aempty_d = (count_d <= AeThrC);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_rd_data      = Fwft ? mem_rd_data : rd_data_q;
  assign o_rd_valid     = Fwft ? ~empty_q    : rd_valid_q;
  assign o_count        = count_q;
  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = afull_q;
  assign o_almost_empty = aempty_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// tb/tb_fifo_lvl.sv - directed self-checking bench driving a registered and an FWFT fifo_lvl
module tb_fifo_lvl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] rd_data_r, rd_data_f;
  logic       rd_valid_r, rd_valid_f;
  logic [4:0] count_r, count_f;
  logic       full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_lvl #(.DataWidth(8), .Depth(16), .Fwft(1'b0)) dut_r (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .i_rd_en(rd_en), .i_clr(clr), .o_rd_data(rd_data_r), .o_rd_valid(rd_valid_r),
    .o_count(count_r), .o_full(full_r), .o_empty(empty_r), .o_almost_full(af_r),
    .o_almost_empty(ae_r), .o_overflow(ovf_r), .o_underflow(unf_r)
  );

  fifo_lvl #(.DataWidth(8), .Depth(16), .Fwft(1'b1)) dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .i_rd_en(rd_en), .i_clr(clr), .o_rd_data(rd_data_f), .o_rd_valid(rd_valid_f),
    .o_count(count_f), .o_full(full_f), .o_empty(empty_f), .o_almost_full(af_f),
    .o_almost_empty(ae_f), .o_overflow(ovf_f), .o_underflow(unf_f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; wr_data = d; rd_en = r; clr = c;
  endtask

  initial begin
    // reset values
    step(); step();
    chk("rst_count", count_r, 0);
    chk("rst_empty", empty_r, 1);
    chk("rst_aempty", ae_r, 1);
    chk("rst_full", full_r, 0);
    chk("rst_afull", af_r, 0);
    chk("rst_rd_data", rd_data_r, 0);
    chk("rst_rd_valid", rd_valid_r, 0);
    chk("rst_ovf", ovf_r, 0);
    chk("rst_unf", unf_r, 0);
    chk("rst_fwft_valid", rd_valid_f, 0);
    rst_n = 1'b1;
    step();

    // fill 0x01..0x10, then one write too many
    for (int i = 1; i <= 16; i++) begin
      drive(1, 8'(i), 0, 0);
      step();
      chk($sformatf("fill_count_%0d", i), count_r, i);
      chk($sformatf("fill_afull_%0d", i), af_r, (i >= 14));
      chk($sformatf("fill_full_%0d", i), full_r, (i == 16));
      chk($sformatf("fill_aempty_%0d", i), ae_r, (i <= 2));
      if (i == 1) begin
        chk("fill_fwft_head", rd_data_f, 8'h01);
        chk("fill_fwft_valid", rd_valid_f, 1);
      end
    end
    drive(1, 8'h99, 0, 0);
    step();
    chk("ovf_count", count_r, 16);
    chk("ovf_flag", ovf_r, 1);
    chk("ovf_flag_fwft", ovf_f, 1);

    // drain in registered mode
    for (int i = 1; i <= 16; i++) begin
      drive(0, 8'h00, 1, 0);
      step();
      chk($sformatf("drain_data_%0d", i), rd_data_r, i);
      chk($sformatf("drain_valid_%0d", i), rd_valid_r, 1);
      chk($sformatf("drain_count_%0d", i), count_r, 16 - i);
      chk($sformatf("drain_aempty_%0d", i), ae_r, ((16 - i) <= 2));
      chk($sformatf("drain_fwft_valid_%0d", i), rd_valid_f, (i < 16));
      if (i < 16) chk($sformatf("drain_fwft_head_%0d", i), rd_data_f, i + 1);
    end
    drive(0, 8'h00, 0, 0);
    step();
    chk("idle_valid_pulse", rd_valid_r, 0);
    chk("idle_data_hold", rd_data_r, 8'h10);
    drive(0, 8'h00, 1, 0);
    step();
    chk("unf_flag", unf_r, 1);
    chk("unf_count", count_r, 0);
    chk("unf_valid", rd_valid_r, 0);
    chk("unf_ovf_sticky", ovf_r, 1);
    drive(0, 8'h00, 0, 1);
    step();
    chk("clr_ovf", ovf_r, 0);
    chk("clr_unf", unf_r, 0);

    // FWFT single word
    drive(1, 8'hA5, 0, 0);
    step();
    chk("fwft_data", rd_data_f, 8'hA5);
    chk("fwft_valid", rd_valid_f, 1);
    drive(0, 8'h00, 1, 0);
    step();
    chk("fwft_empty", empty_f, 1);
    chk("fwft_valid_low", rd_valid_f, 0);
    chk("reg_a5_data", rd_data_r, 8'hA5);

    // full with simultaneous read and write
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(8'h20 + i), 0, 0);
      step();
    end
    chk("pass_pre_full", full_r, 1);
    drive(1, 8'h77, 1, 0);
    step();
    chk("pass_count", count_r, 16);
    chk("pass_full", full_r, 1);
    chk("pass_ovf", ovf_r, 0);
    chk("pass_rd_data", rd_data_r, 8'h20);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 8'h00, 1, 0);
      step();
      chk($sformatf("pass_drain_%0d", i), rd_data_r, (i < 16) ? (8'h20 + i) : 8'h77);
    end
    chk("pass_drained_empty", empty_r, 1);

    // empty with simultaneous read and write
    drive(1, 8'h3C, 1, 0);
    step();
    chk("ew_unf", unf_r, 1);
    chk("ew_count", count_r, 1);
    chk("ew_no_bypass", rd_valid_r, 0);
    chk("ew_fwft_data", rd_data_f, 8'h3C);
    drive(0, 8'h00, 1, 0);
    step();
    chk("ew_read_data", rd_data_r, 8'h3C);
    chk("ew_read_valid", rd_valid_r, 1);
    chk("ew_read_count", count_r, 0);

    // half-fill with sticky flag set, then flush alongside a write
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'(8'h50 + i), 0, 0);
      step();
    end
    chk("half_count", count_r, 8);
    chk("half_unf_sticky", unf_r, 1);
    drive(1, 8'hEE, 0, 1);
    step();
    chk("flush_count", count_r, 0);
    chk("flush_empty", empty_r, 1);
    chk("flush_unf", unf_r, 0);
    chk("flush_ovf", ovf_r, 0);
    chk("flush_aempty", ae_r, 1);
    chk("flush_fwft_valid", rd_valid_f, 0);

    // asynchronous reset in the middle of a write burst
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(8'h60 + i), 0, 0);
      step();
    end
    chk("burst_count", count_r, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count_r, 0);
    chk("async_rst_empty", empty_r, 1);
    chk("async_rst_fwft_count", count_f, 0);
    chk("async_rst_fwft_valid", rd_valid_f, 0);
    drive(0, 8'h00, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_count", count_r, 0);
    chk("post_rst_aempty", ae_r, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
